// File: rtl/parking_gate_controller.sv
// parking_gate_controller: entrance gate FSM with PIN check, lockout, tailgate block, timeout and occupancy
module parking_gate_controller #(
  parameter int CODE_W = 16,
  parameter logic [CODE_W-1:0] PASSWORD = 16'h5990,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT = 64,
  parameter int CAPACITY = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 vehicle_arrival,
  input  logic                                 vehicle_left,
  input  logic                                 vehicle_exit,
  input  logic [CODE_W-1:0]                    code,
  input  logic                                 code_ack,
  output logic                                 gate_open,
  output logic                                 gate_closed,
  output logic                                 wrong_pin_alarm,
  output logic                                 block_alarm,
  output logic                                 full,
  output logic [$clog2(CAPACITY+1)-1:0]        occupancy,
  output logic [$clog2(MAX_TRIES+1)-1:0]       tries
);
  localparam int OCC_W = $clog2(CAPACITY+1);
  localparam int TRY_W = $clog2(MAX_TRIES+1);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT-1);
  typedef enum logic [2:0] {IDLE, WAIT_CODE, OPEN, LOCKOUT, BLOCK} state_t;
  state_t state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [TRY_W-1:0] tries_n;
  logic [OCC_W-1:0] occ_n;
  logic good, bad, inc;
  assign gate_closed = ~gate_open;
  assign full = occupancy == CAP;
  always_comb begin
    good = code_ack && code == PASSWORD;
    bad = code_ack && code != PASSWORD;
    state_n = state;
    timer_n = '0;
    tries_n = tries;
    case (state)
      IDLE: state_n = vehicle_arrival && !full ? WAIT_CODE : IDLE;
      WAIT_CODE:
        if (!vehicle_arrival) state_n = IDLE;
        else if (good) begin
          state_n = OPEN;
          tries_n = '0;
        end else if (bad) begin
          tries_n = tries + 1'b1;
          state_n = tries_n == TRY_MAX ? LOCKOUT : WAIT_CODE;
        end else if (timer == TMR_LAST) state_n = IDLE;
        else timer_n = timer + 1'b1;
      OPEN: state_n = vehicle_left ? (vehicle_arrival ? BLOCK : IDLE) : OPEN;
      LOCKOUT, BLOCK:
        if (good) begin
          state_n = OPEN;
          tries_n = '0;
        end
      default: state_n = IDLE;
    endcase
    inc = state == OPEN && vehicle_left;
    occ_n = (inc && !vehicle_exit && occupancy != CAP) ? occupancy + 1'b1 :
            (!inc && vehicle_exit && occupancy != '0) ? occupancy - 1'b1 : occupancy;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      tries <= '0;
      occupancy <= '0;
      gate_open <= 1'b0;
      wrong_pin_alarm <= 1'b0;
      block_alarm <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      tries <= tries_n;
      occupancy <= occ_n;
      gate_open <= state_n == OPEN;
      wrong_pin_alarm <= state_n == LOCKOUT;
      block_alarm <= state_n == BLOCK;
    end
  end
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: table-driven and directed checks of the parking gate controller
module tb_parking_gate_controller;
  localparam int T = 64;
  localparam logic [15:0] G = 16'h5990;
  localparam logic [15:0] B = 16'h1234;
  logic clk = 0;
  logic rst = 0, arrival = 0, left_s = 0, exit_s = 0, ack = 0;
  logic [15:0] code = '0;
  logic go, gc, wpa, ba, fl;
  logic [3:0] occ;
  logic [1:0] tr;
  logic go2, gc2, wpa2, ba2, fl2;
  logic [1:0] occ2;
  logic [1:0] tr2;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  parking_gate_controller #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .vehicle_arrival(arrival), .vehicle_left(left_s), .vehicle_exit(exit_s),
    .code(code), .code_ack(ack), .gate_open(go), .gate_closed(gc), .wrong_pin_alarm(wpa),
    .block_alarm(ba), .full(fl), .occupancy(occ), .tries(tr)
  );
  parking_gate_controller #(.TIMEOUT(T), .CAPACITY(2)) dut2 (
    .clk(clk), .rst(rst), .vehicle_arrival(arrival), .vehicle_left(left_s), .vehicle_exit(exit_s),
    .code(code), .code_ack(ack), .gate_open(go2), .gate_closed(gc2), .wrong_pin_alarm(wpa2),
    .block_alarm(ba2), .full(fl2), .occupancy(occ2), .tries(tr2)
  );
  typedef struct {
    logic r, a, l, e, k;
    logic [15:0] c;
    int go, wpa, ba, occ, tries;
  } vec_t;
  vec_t tbl[23];
  function automatic vec_t mk(logic r, logic a, logic l, logic e, logic k, logic [15:0] c,
                              int g, int w, int b, int o, int t);
    vec_t v;
    v.r = r; v.a = a; v.l = l; v.e = e; v.k = k; v.c = c;
    v.go = g; v.wpa = w; v.ba = b; v.occ = o; v.tries = t;
    return v;
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic a, input logic l, input logic e, input logic k,
                      input logic [15:0] c);
    rst = r; arrival = a; left_s = l; exit_s = e; ack = k; code = c;
    @(posedge clk);
    #1;
  endtask
  task automatic admit();
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, G);
    step(0, 0, 1, 0, 0, 0);
  endtask
  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 1, G, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 1, 0, 0, 1, B, 0, 0, 0, 1, 1);
    tbl[7]  = mk(0, 1, 0, 0, 1, B, 0, 0, 0, 1, 2);
    tbl[8]  = mk(0, 1, 0, 0, 1, B, 0, 1, 0, 1, 3);
    tbl[9]  = mk(0, 1, 0, 0, 1, B, 0, 1, 0, 1, 3);
    tbl[10] = mk(0, 1, 0, 0, 1, G, 1, 0, 0, 1, 0);
    tbl[11] = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0);
    tbl[12] = mk(0, 1, 0, 0, 1, B, 0, 0, 1, 2, 0);
    tbl[13] = mk(0, 1, 0, 0, 1, G, 1, 0, 0, 2, 0);
    tbl[14] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    tbl[16] = mk(0, 1, 0, 0, 1, G, 1, 0, 0, 3, 0);
    tbl[17] = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 4, 0);
    tbl[18] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(0, 1, 0, 0, 1, G, 1, 0, 0, 0, 0);
    tbl[21] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].a, tbl[i].l, tbl[i].e, tbl[i].k, tbl[i].c);
      chk($sformatf("row%0d gate_open", i), int'(go), tbl[i].go);
      chk($sformatf("row%0d gate_closed", i), int'(gc), 1 - tbl[i].go);
      chk($sformatf("row%0d wrong_pin_alarm", i), int'(wpa), tbl[i].wpa);
      chk($sformatf("row%0d block_alarm", i), int'(ba), tbl[i].ba);
      chk($sformatf("row%0d occupancy", i), int'(occ), tbl[i].occ);
      chk($sformatf("row%0d tries", i), int'(tr), tbl[i].tries);
      chk($sformatf("row%0d full", i), int'(fl), 0);
    end
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    repeat (T - 1) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, G);
    chk("timeout_edge_accept gate_open", int'(go), 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    repeat (T) step(0, 1, 0, 0, 0, 0);
    chk("timeout gate_open", int'(go), 0);
    step(0, 1, 0, 0, 1, G);
    chk("after_timeout code ignored", int'(go), 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, B);
    step(0, 0, 0, 0, 0, 0);
    chk("driver_left tries kept", int'(tr), 1);
    chk("driver_left gate_open", int'(go), 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("exit_at_zero occupancy", int'(occ), 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    admit();
    chk("cap2 occ after 1", int'(occ2), 1);
    chk("cap2 full after 1", int'(fl2), 0);
    admit();
    chk("cap2 occ after 2", int'(occ2), 2);
    chk("cap2 full after 2", int'(fl2), 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, G);
    chk("cap2 full arrival ignored gate_open", int'(go2), 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("cap2 exit occupancy", int'(occ2), 1);
    chk("cap2 exit full", int'(fl2), 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, G);
    chk("cap2 reopen gate_open", int'(go2), 1);
    step(0, 0, 1, 1, 0, 0);
    chk("cap2 entry+exit occupancy", int'(occ2), 1);
    chk("cap2 entry+exit full", int'(fl2), 0);
    chk("cap2 entry+exit gate_open", int'(go2), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
